// File: rtl/bram_sp_be_pipe.sv
// ---------------------------------------------------------------------------
// bram_sp_be_pipe
//   Single-port behavioural block RAM with per-byte write enables, selectable
//   read-during-write behaviour, 1- or 2-cycle read latency, a read-valid
//   strobe, out-of-range flagging and a zero-fill sweep after reset.
//
// Parameters
//   DW         data width in bits (multiple of 8)
//   WL         depth in words (>= 2)
//   AW         address port width (AW >= clog2(WL), AW <= 64)
//   ADDR_SHIFT right shift from byte-style address to word index
//   RD_LAT     read latency, 1 or 2
//   RD_MODE    0 = read-first (old word), 1 = write-first (merged word)
//   INIT_ZERO  1 = zero-fill sweep after reset, 0 = ready after one edge
//
// Ports
//   CLK     clock, rising edge
//   RST     asynchronous active-high reset
//   EN      access request, honoured only while READY=1
//   WE      byte write enables, bit i covers Di[8i+7:8i]
//   A       byte-style address, idx = A >> ADDR_SHIFT
//   Di      write data
//   Do      read data, valid while RVALID=1, holds otherwise
//   RVALID  one-cycle strobe for Do
//   OOR     qualifies RVALID: the access had idx >= WL
//   READY   high when requests are accepted
// ---------------------------------------------------------------------------
module bram_sp_be_pipe #(
   parameter int unsigned DW         = 128,
   parameter int unsigned WL         = 256,
   parameter int unsigned AW         = 13,
   parameter int unsigned ADDR_SHIFT = 2,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned RD_MODE    = 0,
   parameter int unsigned INIT_ZERO  = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic [DW/8-1:0]   WE,
   input  logic [AW-1:0]     A,
   input  logic [DW-1:0]     Di,
   output logic [DW-1:0]     Do,
   output logic              RVALID,
   output logic              OOR,
   output logic              READY
);

   localparam int unsigned NB = DW / 8;
   localparam int unsigned CW = (WL > 1) ? $clog2(WL) : 1;
   localparam logic [CW-1:0] LastWord = CW'(WL - 1);

   typedef enum logic [0:0] {StInit, StRun} state_e;

   // Without a sweep the block comes out of reset directly in RUN; READY
   // still waits for the first edge after release.
   localparam state_e StReset = (INIT_ZERO != 0) ? StInit : StRun;

   // ------------------------------------------------------------------------
   // Storage and control state
   // ------------------------------------------------------------------------
   logic [DW-1:0] mem [WL];

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ready_q, ready_d;

   // ------------------------------------------------------------------------
   // Address decode and read/merge datapath
   // ------------------------------------------------------------------------
   logic [AW-1:0] idx;
   logic [CW-1:0] widx;
   logic          in_range;
   logic          accept;
   logic          wr_en;
   logic [DW-1:0] old_word;
   logic [DW-1:0] new_word;
   logic [DW-1:0] rd_word;

   assign idx      = A >> ADDR_SHIFT;
   assign widx     = CW'(idx);
   // Full-width compare: upper address bits are not masked, they flag OOR.
   assign in_range = 64'(idx) < 64'(WL);

   assign accept   = EN && ready_q && (state_q == StRun);
   assign wr_en    = accept && in_range && (|WE);

   assign old_word = mem[widx];

   always_comb begin
      new_word = old_word;
      for (int i = 0; i < int'(NB); i++) begin
         if (WE[i]) begin
            new_word[8*i +: 8] = Di[8*i +: 8];
         end
      end
   end

   always_comb begin
      rd_word = '0;
      if (in_range) begin
         rd_word = (RD_MODE != 0) ? new_word : old_word;
      end
   end

   // ------------------------------------------------------------------------
   // Array write port: sweep has priority, no accepts happen during it.
   // The array has no reset; a reset while held writes zero to word 0,
   // which the following sweep covers anyway.
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (state_q == StInit) begin
         mem[cnt_q] <= '0;
      end else if (wr_en) begin
         mem[widx] <= new_word;
      end
   end

   // ------------------------------------------------------------------------
   // Sweep / run control
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StReset;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      case (state_q)
         StInit: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastWord) begin
               state_d = StRun;
               ready_d = 1'b1;
               cnt_d   = '0;
            end
         end
         StRun: begin
            ready_d = 1'b1;
         end
         default: begin
            state_d = StInit;
         end
      endcase
   end

   assign READY = ready_q;

   // ------------------------------------------------------------------------
   // Read pipeline stage 1 (registered on the accepting edge).
   // Data only loads on an accept so Do holds between strobes.
   // ------------------------------------------------------------------------
   logic          s1_valid_q;
   logic          s1_oor_q;
   logic [DW-1:0] s1_data_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_valid_q <= 1'b0;
         s1_oor_q   <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= accept;
         s1_oor_q   <= accept && !in_range;
         if (accept) begin
            s1_data_q <= rd_word;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Optional output stage for RD_LAT=2
   // ------------------------------------------------------------------------
   if (RD_LAT == 2) begin : g_lat2
      logic          s2_valid_q;
      logic          s2_oor_q;
      logic [DW-1:0] s2_data_q;

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            s2_valid_q <= 1'b0;
            s2_oor_q   <= 1'b0;
            s2_data_q  <= '0;
         end else begin
            s2_valid_q <= s1_valid_q;
            s2_oor_q   <= s1_oor_q;
            if (s1_valid_q) begin
               s2_data_q <= s1_data_q;
            end
         end
      end

      assign Do     = s2_data_q;
      assign RVALID = s2_valid_q;
      assign OOR    = s2_oor_q;
   end else begin : g_lat1
      assign Do     = s1_data_q;
      assign RVALID = s1_valid_q;
      assign OOR    = s1_oor_q;
   end

endmodule

// File: tb/tb_bram_sp_be_pipe.sv
// ---------------------------------------------------------------------------
// tb_bram_sp_be_pipe
//   Three instances share one stimulus stream: read-first/latency 1,
//   write-first/latency 1 and read-first/latency 2. Each access pushes the
//   hand-computed expected response per instance; a negedge monitor pops and
//   checks data, OOR and latency whenever an instance strobes RVALID.
// ---------------------------------------------------------------------------
module tb_bram_sp_be_pipe;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          EN  = 1'b0;
   logic [15:0]   WE  = '0;
   logic [12:0]   A   = '0;
   logic [127:0]  Di  = '0;

   logic [127:0]  do_rf, do_wf, do_l2;
   logic          rv_rf, rv_wf, rv_l2;
   logic          oor_rf, oor_wf, oor_l2;
   logic          rdy_rf, rdy_wf, rdy_l2;

   bram_sp_be_pipe #(.RD_LAT(1), .RD_MODE(0)) u_rf (
      .CLK(CLK), .RST(RST), .EN(EN), .WE(WE), .A(A), .Di(Di),
      .Do(do_rf), .RVALID(rv_rf), .OOR(oor_rf), .READY(rdy_rf)
   );

   bram_sp_be_pipe #(.RD_LAT(1), .RD_MODE(1)) u_wf (
      .CLK(CLK), .RST(RST), .EN(EN), .WE(WE), .A(A), .Di(Di),
      .Do(do_wf), .RVALID(rv_wf), .OOR(oor_wf), .READY(rdy_wf)
   );

   bram_sp_be_pipe #(.RD_LAT(2), .RD_MODE(0)) u_l2 (
      .CLK(CLK), .RST(RST), .EN(EN), .WE(WE), .A(A), .Di(Di),
      .Do(do_l2), .RVALID(rv_l2), .OOR(oor_l2), .READY(rdy_l2)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [127:0] d;
      logic         oor;
      int           c;
   } exp_t;

   exp_t q_rf[$];
   exp_t q_wf[$];
   exp_t q_l2[$];
   exp_t e_rf, e_wf, e_l2;

   int total = 0;
   int bad   = 0;

   task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: got RVALID=1 expected no strobe (cycle %0d)", name, cyc);
   endtask

   // Monitor
   always @(negedge CLK) begin
      if (rv_rf) begin
         if (q_rf.size() == 0) unexpected("rf_rvalid");
         else begin
            e_rf = q_rf.pop_front();
            cmp("rf_data", do_rf, e_rf.d);
            cmp("rf_oor", 128'(oor_rf), 128'(e_rf.oor));
            cmp("rf_latency", 128'(cyc - e_rf.c), 128'd1);
         end
      end
      if (rv_wf) begin
         if (q_wf.size() == 0) unexpected("wf_rvalid");
         else begin
            e_wf = q_wf.pop_front();
            cmp("wf_data", do_wf, e_wf.d);
            cmp("wf_oor", 128'(oor_wf), 128'(e_wf.oor));
            cmp("wf_latency", 128'(cyc - e_wf.c), 128'd1);
         end
      end
      if (rv_l2) begin
         if (q_l2.size() == 0) unexpected("l2_rvalid");
         else begin
            e_l2 = q_l2.pop_front();
            cmp("l2_data", do_l2, e_l2.d);
            cmp("l2_oor", 128'(oor_l2), 128'(e_l2.oor));
            cmp("l2_latency", 128'(cyc - e_l2.c), 128'd2);
         end
      end
   end

   // One accepted access; expected read-first and write-first results.
   task automatic acc(input logic [15:0] we, input logic [12:0] a, input logic [127:0] d,
                      input logic [127:0] exp_rf, input logic [127:0] exp_wf,
                      input logic exp_oor);
      exp_t t;
      EN = 1'b1;
      WE = we;
      A  = a;
      Di = d;
      t.oor = exp_oor;
      t.c   = cyc;
      t.d   = exp_rf;
      q_rf.push_back(t);
      q_l2.push_back(t);
      t.d   = exp_wf;
      q_wf.push_back(t);
      @(posedge CLK);
      #1;
   endtask

   task automatic rd(input logic [12:0] a, input logic [127:0] exp);
      acc(16'h0000, a, '0, exp, exp, 1'b0);
   endtask

   task automatic idle(input int n);
      EN = 1'b0;
      WE = '0;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Called just after RST release; counts edges until READY.
   task automatic wait_ready(input string tag);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 400) begin
         @(posedge CLK);
         n++;
         @(negedge CLK);
         if (n == 255) cmp({tag, "_ready_low_at_255"}, 128'({rdy_rf, rdy_wf, rdy_l2}), 128'd0);
         if (rdy_rf) begin
            seen = 1'b1;
            EN   = 1'b0;
            WE   = '0;
         end
      end
      cmp({tag, "_ready_edge"}, 128'(n), 128'd256);
      cmp({tag, "_ready_all"}, 128'({rdy_rf, rdy_wf, rdy_l2}), 128'b111);
   endtask

   logic [127:0] b_aa, b_55, b_11, b_22, merged;
   logic [127:0] blk [4];

   initial begin
      b_aa   = {16{8'hAA}};
      b_55   = {16{8'h55}};
      b_11   = {16{8'h11}};
      b_22   = {16{8'h22}};
      merged = {{12{8'hAA}}, {4{8'h55}}};
      blk[0] = {16{8'h31}};
      blk[1] = {16{8'h32}};
      blk[2] = {16{8'h33}};
      blk[3] = {16{8'h34}};

      // Reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      cmp("reset_flags", 128'({rv_rf, oor_rf, rdy_rf, rv_wf, oor_wf, rdy_wf,
                               rv_l2, oor_l2, rdy_l2}), 128'd0);
      cmp("reset_do_rf", do_rf, '0);
      cmp("reset_do_l2", do_l2, '0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      wait_ready("sweep1");

      // Swept contents read zero
      rd(13'h000, '0);
      rd(13'h3FC, '0);

      // Byte-enable merge
      acc(16'hFFFF, 13'h010, b_aa, '0, b_aa, 1'b0);
      acc(16'h000F, 13'h010, b_55, b_aa, merged, 1'b0);
      rd(13'h010, merged);
      rd(13'h013, merged);  // low address bits ignored
      idle(3);
      cmp("rf_do_hold", do_rf, merged);
      cmp("wf_do_hold", do_wf, merged);
      cmp("l2_do_hold", do_l2, merged);

      // Read during write
      acc(16'hFFFF, 13'h020, b_11, '0, b_11, 1'b0);
      acc(16'hFFFF, 13'h020, b_22, b_11, b_22, 1'b0);
      rd(13'h020, b_22);

      // Back-to-back writes then reads
      for (int i = 0; i < 4; i++) acc(16'hFFFF, 13'(13'h030 + 4 * i), blk[i], '0, blk[i], 1'b0);
      for (int i = 0; i < 4; i++) rd(13'(13'h030 + 4 * i), blk[i]);

      // Out of range: no write, no wrap
      acc(16'hFFFF, 13'h400, {16{8'hFF}}, '0, '0, 1'b1);
      acc(16'h0000, 13'h400, '0, '0, '0, 1'b1);
      rd(13'h000, '0);
      acc(16'hFFFF, 13'h1FFC, {16{8'hEE}}, '0, '0, 1'b1);
      rd(13'h3FC, '0);
      idle(4);

      // Reset with a read in flight; requests held during the sweep
      EN = 1'b1;
      WE = '0;
      A  = 13'h010;
      @(posedge CLK);
      #1;
      RST = 1'b1;
      EN  = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      EN  = 1'b1;
      WE  = 16'hFFFF;
      A   = 13'h040;
      Di  = {16{8'h77}};
      wait_ready("sweep2");
      rd(13'h010, '0);
      rd(13'h030, '0);
      rd(13'h040, '0);
      idle(4);

      cmp("rf_queue_drained", 128'(q_rf.size()), 128'd0);
      cmp("wf_queue_drained", 128'(q_wf.size()), 128'd0);
      cmp("l2_queue_drained", 128'(q_l2.size()), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog");
   end

endmodule
